hs_ram_arbiter: RTL and testbench

Shares the Bagman work RAM's single synchronous port between the Z80 bus and the hiscore save/restore engine. The arbiter sits inside the bagman core, between the CPU address decode and the work-RAM instance. When the hiscore engine signals read or write intent, the arbiter halts the CPU and waits for the bus to drain. It then hands the RAM port to the hiscore engine and returns the port to the CPU once intent drops.

---
 rtl/bagman_pkg.sv | 15 +
 rtl/hs_ram_arbiter.sv | 134 +++++++++++++
 tb/tb_hs_ram_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bagman_pkg.sv
// Shared constants for the Bagman core: work-RAM geometry and the
// state encoding of the hiscore/CPU work-RAM arbiter.
package bagman_pkg;

   localparam int WORK_RAM_ADDR_W = 11;

   // Kept as plain 2-bit constants so older netlists and probes still line up
   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ST_IDLE    = 2'd0;
   localparam arb_state_t ST_DRAIN   = 2'd1;
   localparam arb_state_t ST_GRANT   = 2'd2;
   localparam arb_state_t ST_RELEASE = 2'd3;

endpackage

// File: rtl/hs_ram_arbiter.sv
// Shares the work RAM's single synchronous port between the Z80 bus and the
// hiscore engine: halts the CPU, waits for its bus to go quiet, then hands over.
module hs_ram_arbiter
   import bagman_pkg::*;
#(
   parameter int ADDR_W       = WORK_RAM_ADDR_W,
   parameter int DRAIN_CYCLES = 3
)
(
   input  logic              clock_12mhz,
   input  logic              reset,
   input  logic              paused,
   input  logic              cpu_ce,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_dout,
   output logic [7:0]        cpu_din,
   output logic              cpu_pause,
   input  logic              hs_read_intent,
   input  logic              hs_write_intent,
   input  logic [ADDR_W-1:0] hs_address,
   input  logic [7:0]        hs_data_in,
   input  logic              hs_write_enable,
   output logic [7:0]        hs_data_out,
   output logic              hs_grant,
   output logic              hs_err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_din,
   input  logic [7:0]        ram_dout
);

   localparam logic [3:0] DRAIN_LIMIT = 4'(DRAIN_CYCLES);

   arb_state_t state;
   arb_state_t state_next;
   logic [3:0] idle_cnt;
   logic [3:0] idle_cnt_next;
   logic [7:0] cpu_din_hold;
   logic       intent;
   logic       cpu_owns_port;

   assign intent        = hs_read_intent | hs_write_intent;
   assign cpu_owns_port = (state == ST_IDLE) || (state == ST_DRAIN);

   // Next-state and idle counter; the grant decision uses the updated count so
   // that DRAIN_CYCLES quiet cycles in DRAIN lead straight into GRANT.
   always_comb begin
      state_next    = state;
      idle_cnt_next = idle_cnt;
      case (state)
         ST_IDLE: begin
            idle_cnt_next = 4'd0;
            if (intent) begin
               state_next = paused ? ST_GRANT : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (cpu_ce) begin
               idle_cnt_next = 4'd0;
            end else if (idle_cnt != 4'hF) begin
               idle_cnt_next = idle_cnt + 4'd1;
            end
            if (!intent) begin
               state_next = ST_RELEASE;
            end else if (paused || (idle_cnt_next == DRAIN_LIMIT)) begin
               state_next = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (!intent) begin
               state_next = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // RAM port mux; a reset cycle suppresses any write so nothing half-lands
   always_comb begin
      ram_addr = cpu_addr;
      ram_din  = cpu_dout;
      ram_we   = 1'b0;
      case (state)
         ST_IDLE, ST_DRAIN: begin
            ram_we = cpu_ce & cpu_we;
         end
         ST_GRANT: begin
            ram_addr = hs_address;
            ram_din  = hs_data_in;
            ram_we   = hs_write_enable;
         end
         default: begin
            ram_we = 1'b0;
         end
      endcase
      if (reset) begin
         ram_we = 1'b0;
      end
   end

   always_ff @(posedge clock_12mhz) begin
      if (reset) begin
         state        <= ST_IDLE;
         idle_cnt     <= 4'd0;
         hs_data_out  <= 8'h00;
         hs_err       <= 1'b0;
         cpu_din_hold <= 8'h00;
      end else begin
         state    <= state_next;
         idle_cnt <= idle_cnt_next;
         if (state == ST_GRANT) begin
            hs_data_out <= ram_dout;
         end
         if (hs_write_enable && (state != ST_GRANT)) begin
            hs_err <= 1'b1;
         end
         if (cpu_owns_port) begin
            cpu_din_hold <= ram_dout;
         end
      end
   end

   // While the hiscore engine owns the port the CPU keeps seeing its own last read
   assign cpu_din   = cpu_owns_port ? ram_dout : cpu_din_hold;
   assign cpu_pause = (state != ST_IDLE);
   assign hs_grant  = (state == ST_GRANT);

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter with a behavioural 2 KB synchronous RAM
// attached to the ram_* port.
module tb_hs_ram_arbiter;

   localparam int ADDR_W = 11;

   logic              clock_12mhz = 1'b0;
   logic              reset;
   logic              paused;
   logic              cpuCe;
   logic              cpuWe;
   logic [ADDR_W-1:0] cpuAddr;
   logic [7:0]        cpuDout;
   logic [7:0]        cpuDin;
   logic              cpuPause;
   logic              hsReadIntent;
   logic              hsWriteIntent;
   logic [ADDR_W-1:0] hsAddress;
   logic [7:0]        hsDataIn;
   logic              hsWriteEnable;
   logic [7:0]        hsDataOut;
   logic              hsGrant;
   logic              hsErr;
   logic [ADDR_W-1:0] ramAddr;
   logic              ramWe;
   logic [7:0]        ramDin;
   logic [7:0]        ramDout;

   logic [7:0] workRam [0:2047];

   int checkCount = 0;
   int errorCount = 0;

   always #5 clock_12mhz = ~clock_12mhz;

   hs_ram_arbiter #(.ADDR_W(ADDR_W), .DRAIN_CYCLES(3)) dut (
      .clock_12mhz     (clock_12mhz),
      .reset           (reset),
      .paused          (paused),
      .cpu_ce          (cpuCe),
      .cpu_we          (cpuWe),
      .cpu_addr        (cpuAddr),
      .cpu_dout        (cpuDout),
      .cpu_din         (cpuDin),
      .cpu_pause       (cpuPause),
      .hs_read_intent  (hsReadIntent),
      .hs_write_intent (hsWriteIntent),
      .hs_address      (hsAddress),
      .hs_data_in      (hsDataIn),
      .hs_write_enable (hsWriteEnable),
      .hs_data_out     (hsDataOut),
      .hs_grant        (hsGrant),
      .hs_err          (hsErr),
      .ram_addr        (ramAddr),
      .ram_we          (ramWe),
      .ram_din         (ramDin),
      .ram_dout        (ramDout)
   );

   // Single-port synchronous RAM, read-before-write
   always @(posedge clock_12mhz) begin
      if (ramWe) begin
         workRam[ramAddr] <= ramDin;
      end
      ramDout <= workRam[ramAddr];
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are driven
   task automatic nextCycle();
      @(posedge clock_12mhz);
      #1;
   endtask

   task automatic applyStimulus(input logic ce, input logic we, input logic [ADDR_W-1:0] addr, input logic [7:0] data);
      cpuCe   = ce;
      cpuWe   = we;
      cpuAddr = addr;
      cpuDout = data;
      #1;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) workRam[i] = 8'h00;
      workRam[11'h010] = 8'hA5;
      workRam[11'h020] = 8'h5A;
      ramDout       = 8'h00;
      reset         = 1'b1;
      paused        = 1'b0;
      cpuCe         = 1'b0;
      cpuWe         = 1'b0;
      cpuAddr       = '0;
      cpuDout       = 8'h00;
      hsReadIntent  = 1'b0;
      hsWriteIntent = 1'b0;
      hsAddress     = '0;
      hsDataIn      = 8'h00;
      hsWriteEnable = 1'b0;

      nextCycle();
      nextCycle();
      reset = 1'b0;
      #1;
      checkOutput("reset_cpu_pause", 16'(cpuPause), 16'h0);
      checkOutput("reset_hs_grant", 16'(hsGrant), 16'h0);
      checkOutput("reset_hs_err", 16'(hsErr), 16'h0);
      checkOutput("reset_hs_data_out", 16'(hsDataOut), 16'h00);

      // Read grant with an idle CPU; CPU last read address 0x020 (0x5A)
      nextCycle();
      hsReadIntent = 1'b1;
      hsAddress    = 11'h010;
      applyStimulus(1'b0, 1'b0, 11'h020, 8'h00);
      checkOutput("c0_cpu_pause", 16'(cpuPause), 16'h0);
      nextCycle();
      checkOutput("c1_cpu_pause", 16'(cpuPause), 16'h1);
      checkOutput("c1_hs_grant", 16'(hsGrant), 16'h0);
      nextCycle();
      nextCycle();
      checkOutput("c3_hs_grant", 16'(hsGrant), 16'h0);
      nextCycle();
      checkOutput("c4_hs_grant", 16'(hsGrant), 16'h1);
      checkOutput("c4_ram_addr", 16'(ramAddr), 16'h010);
      nextCycle();
      checkOutput("c5_cpu_din_held", 16'(cpuDin), 16'h5A);
      nextCycle();
      checkOutput("c6_hs_data_out", 16'(hsDataOut), 16'hA5);
      checkOutput("c6_cpu_din_held", 16'(cpuDin), 16'h5A);
      hsReadIntent = 1'b0;
      nextCycle();
      checkOutput("c7_release_grant", 16'(hsGrant), 16'h0);
      checkOutput("c7_release_pause", 16'(cpuPause), 16'h1);
      checkOutput("c7_release_we", 16'(ramWe), 16'h0);
      checkOutput("c7_cpu_din_held", 16'(cpuDin), 16'h5A);
      nextCycle();
      checkOutput("c8_idle_pause", 16'(cpuPause), 16'h0);

      // CPU strobes in DRAIN restart the idle count
      nextCycle();
      hsReadIntent = 1'b1;
      applyStimulus(1'b0, 1'b0, 11'h030, 8'h00);
      nextCycle();
      nextCycle();
      applyStimulus(1'b1, 1'b1, 11'h030, 8'h11);
      checkOutput("d2_drain_cpu_we", 16'(ramWe), 16'h1);
      checkOutput("d2_drain_pause", 16'(cpuPause), 16'h1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 11'h030, 8'h00);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 11'h030, 8'h00);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 11'h030, 8'h00);
      nextCycle();
      nextCycle();
      checkOutput("d7_hs_grant", 16'(hsGrant), 16'h0);
      nextCycle();
      checkOutput("d8_hs_grant", 16'(hsGrant), 16'h1);
      checkOutput("d_cpu_write_landed", 16'(workRam[11'h030]), 16'h11);
      hsReadIntent = 1'b0;
      nextCycle();
      nextCycle();

      // Paused CPU: immediate grant, hiscore write wins over a CPU write
      nextCycle();
      paused        = 1'b1;
      hsWriteIntent = 1'b1;
      hsAddress     = 11'h7FF;
      hsDataIn      = 8'h3C;
      #1;
      nextCycle();
      checkOutput("e1_hs_grant", 16'(hsGrant), 16'h1);
      hsWriteEnable = 1'b1;
      applyStimulus(1'b1, 1'b1, 11'h7FF, 8'hEE);
      checkOutput("e1_ram_we", 16'(ramWe), 16'h1);
      checkOutput("e1_ram_addr", 16'(ramAddr), 16'h7FF);
      checkOutput("e1_ram_din", 16'(ramDin), 16'h3C);
      nextCycle();
      hsWriteEnable = 1'b0;
      #1;
      checkOutput("e2_cpu_write_blocked", 16'(ramWe), 16'h0);
      checkOutput("e2_ram_7ff", 16'(workRam[11'h7FF]), 16'h3C);
      hsWriteIntent = 1'b0;
      nextCycle();
      checkOutput("e3_release_we", 16'(ramWe), 16'h0);
      applyStimulus(1'b0, 1'b0, 11'h000, 8'h00);
      paused = 1'b0;
      nextCycle();
      checkOutput("e4_ram_7ff", 16'(workRam[11'h7FF]), 16'h3C);
      checkOutput("e4_hs_err", 16'(hsErr), 16'h0);

      // Stray hiscore write in IDLE is dropped and flagged
      hsAddress     = 11'h040;
      hsDataIn      = 8'h99;
      hsWriteEnable = 1'b1;
      #1;
      checkOutput("f0_idle_we", 16'(ramWe), 16'h0);
      nextCycle();
      hsWriteEnable = 1'b0;
      #1;
      checkOutput("f1_hs_err", 16'(hsErr), 16'h1);
      checkOutput("f1_ram_040", 16'(workRam[11'h040]), 16'h00);
      paused        = 1'b1;
      hsReadIntent  = 1'b1;
      nextCycle();
      checkOutput("f2_hs_grant", 16'(hsGrant), 16'h1);
      checkOutput("f2_hs_err_sticky", 16'(hsErr), 16'h1);

      // Reset while granted with a write strobe pending
      hsAddress     = 11'h050;
      hsDataIn      = 8'h77;
      hsWriteEnable = 1'b1;
      reset         = 1'b1;
      #1;
      nextCycle();
      checkOutput("g_reset_ram_we", 16'(ramWe), 16'h0);
      checkOutput("g_reset_cpu_pause", 16'(cpuPause), 16'h0);
      checkOutput("g_reset_hs_grant", 16'(hsGrant), 16'h0);
      checkOutput("g_reset_hs_err", 16'(hsErr), 16'h0);
      checkOutput("g_reset_ram_050", 16'(workRam[11'h050]), 16'h00);
      reset         = 1'b0;
      hsWriteEnable = 1'b0;
      hsReadIntent  = 1'b0;
      paused        = 1'b0;
      nextCycle();
      nextCycle();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
